hsv_core_mem_issue: RTL and testbench
=====================================

HSV_CORE_MEM_ISSUE -- requirements
Module: hsv_core_mem_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have parameter PENDING_DEPTH, default 8, meaning outstanding reads (and, separately, writes) tracked; power of 2, at least 2.
REQ-004 SHALL have ports (clock and reset first):
clk_core  in  1  sole clock
rst_core  in  1  synchronous active-high reset
flush  in  1  discard head request; return to RUN
flush_req  in  1  flush pending; restrict issue
req_valid  in  1; req_ready  out  1  request handshake
req_addr  in  ADDR_WIDTH; req_write  in  1  1=write
req_wdata  in  DATA_WIDTH; req_wstrb  in  DATA_WIDTH/8
req_is_memory  in  1  RAM/ROM, not I/O
req_misaligned  in  1; req_fence  in  1
req_commit_head  in  1  commit is waiting for this request
ar_valid/ar_addr  out  1/ADDR_WIDTH; ar_ready  in  1
aw_valid/aw_addr  out  1/ADDR_WIDTH; aw_ready  in  1
w_valid/w_data/w_strb  out  1/DATA_WIDTH/DATA_WIDTH/8; w_ready  in  1
rd_retire  in  1  oldest read completed; wr_retire  in  1  oldest write completed
write_credit  in  1  commit grants one memory-write credit
pending_reads  out  $clog2(PENDING_DEPTH)+1; pending_writes  out  same width
busy  out  1  any entry pending or any channel valid

Function
REQ-005 Word address SHALL be req_addr with the low $clog2(DATA_WIDTH/8) bits forced to zero; ar_addr and aw_addr SHALL always carry word addresses.
REQ-006 Per direction, SHALL keep an internal FIFO of word addresses: push on issue, pop on retire; push and pop in the same cycle leave the count unchanged.
REQ-007 A retire with an empty FIFO SHALL be ignored, with no count underflow.
REQ-008 Channel outputs SHALL be registered; once a valid is high, that channel's valid, address, data and strobe SHALL hold until the ready is sampled high, including across flush.
REQ-009 A channel slot is free when its valid is low or its ready is high in the same cycle.
REQ-010 A read SHALL issue when: AR slot free; read FIFO not full; no valid write FIFO entry equals its word address; and (req_is_memory or req_commit_head).
REQ-011 A write SHALL issue when: AW and W slots free; write FIFO not full; no valid read FIFO entry equals its word address; and (req_commit_head or (req_is_memory and credit > 0)).
REQ-012 Credit SHALL be a signed $clog2(PENDING_DEPTH)+3-bit counter: +1 on write_credit; -1 on each issued write with req_is_memory; both in one cycle leave it unchanged; saturates at both extremes.
REQ-013 req_ready SHALL be 1 in the cycle a request issues; latency is 1 cycle from handshake to the channel valid.
REQ-014 A misaligned request SHALL be accepted with req_ready=1, with no AXI traffic, no FIFO push and no credit change.
REQ-015 FSM states RUN, FENCE, DRAIN; reset state RUN.
REQ-016 RUN -> FENCE when req_valid and req_fence; req_ready stays 0 until pending_reads=0, pending_writes=0 and all channel valids are 0; then req_ready=1 for one cycle and the FSM returns to RUN.
REQ-017 RUN or FENCE -> DRAIN on flush_req; in DRAIN no read SHALL issue, and writes SHALL issue only under REQ-011 with credit > 0.
REQ-018 flush SHALL force the FSM to RUN and drop the current request without issuing it; FIFOs and credit SHALL be kept so that in-flight responses still retire.
REQ-019 flush takes priority over flush_req, fence and issue when they occur in the same cycle.

Reset
REQ-020 On rst_core, at the clock edge: all valids 0, FIFOs empty, pending counts 0, credit 0, FSM RUN, req_ready 0, busy 0.
REQ-021 Data and address registers MAY stay non-reset; they SHALL NOT be observed while the matching valid is 0.
REQ-022 Reset asserted mid-transaction SHALL abandon all outstanding state, with no ready required.

Verification
REQ-023 Memory read 0x1003, DATA_WIDTH=32, ar_ready=1 -> next cycle ar_valid=1, ar_addr=0x1000, pending_reads=1; rd_retire -> 0.
REQ-024 Pending write to 0x2000 not retired, then read of 0x2004 issues and read of 0x2000 stalls -> read issues the cycle after wr_retire.
REQ-025 Memory write with credit 0 -> req_ready=0; one write_credit pulse -> write issues, credit returns to 0; I/O write with req_commit_head=1 issues with credit 0.
REQ-026 aw_ready held 0 for 5 cycles with flush in cycle 2 -> aw_valid and aw_addr stable through the 5 cycles; pending_writes unchanged by flush.
REQ-027 Fill PENDING_DEPTH reads -> next read stalls; rd_retire and a new issue in the same cycle -> count stays PENDING_DEPTH.
REQ-028 Fence with 2 reads outstanding -> req_ready=0 until both retire and ar_valid=0, then exactly one ready pulse; flush_req during it -> DRAIN, no further AR.

Source files
------------

// File: rtl/hsv_core_mem_issue_if.sv
// ---------------------------------------------------------------------------
// hsv_core_mem_issue_if
//   Bundles the request handshake from the core and the three outgoing
//   memory-bus channels (AR, AW, W) of the memory issue unit.
//
//   master : the issue unit. Accepts requests, drives the bus channels.
//   slave  : the environment. Presents requests, accepts the bus channels.
//
//   Request side : req_valid/req_ready, req_addr, req_write, req_wdata,
//                  req_wstrb, req_is_memory, req_misaligned, req_fence,
//                  req_commit_head
//   Read address : ar_valid, ar_addr, ar_ready
//   Write address: aw_valid, aw_addr, aw_ready
//   Write data   : w_valid, w_data, w_strb, w_ready
// ---------------------------------------------------------------------------
interface hsv_core_mem_issue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_write;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    req_is_memory;
  logic                    req_misaligned;
  logic                    req_fence;
  logic                    req_commit_head;

  logic                    ar_valid;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_ready;

  logic                    aw_valid;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_ready;

  logic                    w_valid;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_ready;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
           req_is_memory, req_misaligned, req_fence, req_commit_head,
    output req_ready,
    output ar_valid, ar_addr,
    input  ar_ready,
    output aw_valid, aw_addr,
    input  aw_ready,
    output w_valid, w_data, w_strb,
    input  w_ready
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb,
           req_is_memory, req_misaligned, req_fence, req_commit_head,
    input  req_ready,
    input  ar_valid, ar_addr,
    output ar_ready,
    input  aw_valid, aw_addr,
    output aw_ready,
    input  w_valid, w_data, w_strb,
    output w_ready
  );
endinterface

// File: rtl/hsv_core_mem_issue.sv
// ---------------------------------------------------------------------------
// hsv_core_mem_issue
//   Issues core load/store requests onto AR/AW/W channels. Tracks
//   outstanding reads and writes in per-direction address FIFOs so that a
//   read never overtakes a write to the same word (and vice versa), gates
//   speculative memory writes on credits granted by commit, and implements
//   fence (wait for quiescence) and flush/drain handling.
//
//   Ports
//     clk_core        sole clock
//     rst_core        synchronous active-high reset
//     flush           drop the head request, return the FSM to RUN
//     flush_req       a flush is pending: stop reads, writes only on credit
//     rd_retire       oldest outstanding read completed
//     wr_retire       oldest outstanding write completed
//     write_credit    commit grants one memory-write credit
//     pending_reads   number of outstanding reads
//     pending_writes  number of outstanding writes
//     busy            any entry outstanding or any channel valid
//     bus             request handshake + AR/AW/W channels (master side)
//
//   DATA_WIDTH must be 32 or 64; PENDING_DEPTH a power of two, >= 2.
// ---------------------------------------------------------------------------
module hsv_core_mem_issue #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int PENDING_DEPTH = 8
) (
  input  logic                            clk_core,
  input  logic                            rst_core,
  input  logic                            flush,
  input  logic                            flush_req,
  input  logic                            rd_retire,
  input  logic                            wr_retire,
  input  logic                            write_credit,
  output logic [$clog2(PENDING_DEPTH):0]  pending_reads,
  output logic [$clog2(PENDING_DEPTH):0]  pending_writes,
  output logic                            busy,
  hsv_core_mem_issue_if.master            bus
);

  localparam int PTR_W = $clog2(PENDING_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CR_W  = PTR_W + 3;
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(PENDING_DEPTH);

  localparam logic signed [CR_W-1:0] CR_ZERO = '0;
  localparam logic signed [CR_W-1:0] CR_ONE  = CR_W'(1);
  localparam logic signed [CR_W-1:0] CR_MAX  = {1'b0, {(CR_W-1){1'b1}}};
  localparam logic signed [CR_W-1:0] CR_MIN  = {1'b1, {(CR_W-1){1'b0}}};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FENCE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Occupancy update: simultaneous push and pop cancel out.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             push,
                                                input logic             pop);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (push && !pop) nxt = cnt + CNT_ONE;
    else if (pop && !push) nxt = cnt - CNT_ONE;
    return nxt;
  endfunction

  // Saturating credit update in both directions.
  function automatic logic signed [CR_W-1:0] credit_next(input logic signed [CR_W-1:0] cur,
                                                         input logic                   inc,
                                                         input logic                   dec);
    logic signed [CR_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != CR_MAX)) nxt = cur + CR_ONE;
    else if (dec && !inc && (cur != CR_MIN)) nxt = cur - CR_ONE;
    return nxt;
  endfunction

  state_e state_q, state_d;

  // Control state (reset)
  logic                     ar_valid_q, aw_valid_q, w_valid_q;
  logic [PENDING_DEPTH-1:0] rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
  logic [PTR_W-1:0]         rd_wptr_q, rd_rptr_q, wr_wptr_q, wr_rptr_q;
  logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic signed [CR_W-1:0]   credit_q, credit_d;

  // Data state (no reset; only observed under the matching valid)
  logic [ADDR_WIDTH-1:0]    rd_mem_q [PENDING_DEPTH];
  logic [ADDR_WIDTH-1:0]    wr_mem_q [PENDING_DEPTH];
  logic [ADDR_WIDTH-1:0]    ar_addr_q, aw_addr_q;
  logic [DATA_WIDTH-1:0]    w_data_q;
  logic [DATA_WIDTH/8-1:0]  w_strb_q;

  logic [ADDR_WIDTH-1:0]    waddr;
  logic                     rd_hazard, wr_hazard;
  logic                     rd_pop, wr_pop, rd_room, wr_room;
  logic                     ar_free, aw_free, w_free;
  logic                     credit_pos, quiet;
  logic                     mem_req, fence_req, mis_ok;
  logic                     rd_ok, wr_ok, wr_ok_drain;
  logic                     issue_rd, issue_wr, req_ready_c;

  assign waddr = bus.req_addr & ~OFF_MASK;

  // Retires against an empty FIFO are dropped here, so counts never wrap.
  assign rd_pop = rd_retire && (rd_cnt_q != '0);
  assign wr_pop = wr_retire && (wr_cnt_q != '0);

  // A full FIFO still accepts a push in the cycle its oldest entry retires.
  assign rd_room = (rd_cnt_q != CNT_FULL) || rd_pop;
  assign wr_room = (wr_cnt_q != CNT_FULL) || wr_pop;

  assign ar_free = !ar_valid_q || bus.ar_ready;
  assign aw_free = !aw_valid_q || bus.aw_ready;
  assign w_free  = !w_valid_q  || bus.w_ready;

  assign credit_pos = credit_q > CR_ZERO;

  assign quiet = (rd_cnt_q == '0) && (wr_cnt_q == '0) &&
                 !ar_valid_q && !aw_valid_q && !w_valid_q;

  // Ordering hazard: compare against registered entries only, so an access
  // blocked by a same-word entry issues the cycle after that entry retires.
  always_comb begin
    rd_hazard = 1'b0;
    wr_hazard = 1'b0;
    for (int i = 0; i < PENDING_DEPTH; i++) begin
      if (wr_vld_q[i] && (wr_mem_q[i] == waddr)) rd_hazard = 1'b1;
      if (rd_vld_q[i] && (rd_mem_q[i] == waddr)) wr_hazard = 1'b1;
    end
  end

  assign mem_req   = bus.req_valid && !bus.req_fence && !bus.req_misaligned;
  assign fence_req = bus.req_valid && bus.req_fence;
  assign mis_ok    = bus.req_valid && !bus.req_fence && bus.req_misaligned;

  assign rd_ok = mem_req && !bus.req_write && ar_free && rd_room && !rd_hazard &&
                 (bus.req_is_memory || bus.req_commit_head);

  assign wr_ok = mem_req && bus.req_write && aw_free && w_free && wr_room && !wr_hazard &&
                 (bus.req_commit_head || (bus.req_is_memory && credit_pos));

  // While draining, even commit-head writes wait for a positive credit.
  assign wr_ok_drain = wr_ok && credit_pos;

  always_comb begin
    state_d     = state_q;
    issue_rd    = 1'b0;
    issue_wr    = 1'b0;
    req_ready_c = 1'b0;
    if (flush) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (flush_req) begin
            state_d     = DRAIN;
            issue_wr    = wr_ok_drain;
            req_ready_c = wr_ok_drain || mis_ok;
          end else if (fence_req) begin
            state_d = FENCE;
          end else begin
            issue_rd    = rd_ok;
            issue_wr    = wr_ok;
            req_ready_c = rd_ok || wr_ok || mis_ok;
          end
        end
        FENCE: begin
          if (flush_req) begin
            state_d = DRAIN;
          end else if (quiet) begin
            req_ready_c = 1'b1;
            state_d     = RUN;
          end
        end
        DRAIN: begin
          issue_wr    = wr_ok_drain;
          req_ready_c = wr_ok_drain || mis_ok;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    rd_vld_d = rd_vld_q;
    wr_vld_d = wr_vld_q;
    if (rd_pop)   rd_vld_d[rd_rptr_q] = 1'b0;
    if (issue_rd) rd_vld_d[rd_wptr_q] = 1'b1;
    if (wr_pop)   wr_vld_d[wr_rptr_q] = 1'b0;
    if (issue_wr) wr_vld_d[wr_wptr_q] = 1'b1;
  end

  assign rd_cnt_d = cnt_next(rd_cnt_q, issue_rd, rd_pop);
  assign wr_cnt_d = cnt_next(wr_cnt_q, issue_wr, wr_pop);
  assign credit_d = credit_next(credit_q, write_credit, issue_wr && bus.req_is_memory);

  // ---- request decode / issue -> registered channel state ----
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q    <= RUN;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      rd_vld_q   <= '0;
      wr_vld_q   <= '0;
      rd_wptr_q  <= '0;
      rd_rptr_q  <= '0;
      wr_wptr_q  <= '0;
      wr_rptr_q  <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      credit_q   <= CR_ZERO;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rd_vld_d;
      wr_vld_q <= wr_vld_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      credit_q <= credit_d;
      if (issue_rd) rd_wptr_q <= rd_wptr_q + PTR_ONE;
      if (rd_pop)   rd_rptr_q <= rd_rptr_q + PTR_ONE;
      if (issue_wr) wr_wptr_q <= wr_wptr_q + PTR_ONE;
      if (wr_pop)   wr_rptr_q <= wr_rptr_q + PTR_ONE;

      // Issue only happens into a free slot, so a new beat never
      // overwrites one still waiting for its ready.
      if (issue_rd)          ar_valid_q <= 1'b1;
      else if (bus.ar_ready) ar_valid_q <= 1'b0;
      if (issue_wr)          aw_valid_q <= 1'b1;
      else if (bus.aw_ready) aw_valid_q <= 1'b0;
      if (issue_wr)          w_valid_q  <= 1'b1;
      else if (bus.w_ready)  w_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk_core) begin
    if (issue_rd) begin
      ar_addr_q           <= waddr;
      rd_mem_q[rd_wptr_q] <= waddr;
    end
    if (issue_wr) begin
      aw_addr_q           <= waddr;
      w_data_q            <= bus.req_wdata;
      w_strb_q            <= bus.req_wstrb;
      wr_mem_q[wr_wptr_q] <= waddr;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.ar_valid  = ar_valid_q;
  assign bus.ar_addr   = ar_addr_q;
  assign bus.aw_valid  = aw_valid_q;
  assign bus.aw_addr   = aw_addr_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.w_data    = w_data_q;
  assign bus.w_strb    = w_strb_q;

  assign pending_reads  = rd_cnt_q;
  assign pending_writes = wr_cnt_q;
  assign busy           = (rd_cnt_q != '0) || (wr_cnt_q != '0) ||
                          ar_valid_q || aw_valid_q || w_valid_q;

endmodule

// File: tb/tb_hsv_core_mem_issue.sv
// ---------------------------------------------------------------------------
// tb_hsv_core_mem_issue
//   Directed bench for hsv_core_mem_issue (DATA_WIDTH=32, PENDING_DEPTH=8).
//   Expected channel beats are queued when a request is driven and popped
//   when the corresponding channel valid is observed.
// ---------------------------------------------------------------------------
module tb_hsv_core_mem_issue;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int PD = 8;
  localparam int CW = $clog2(PD) + 1;

  logic          clk_core = 1'b0;
  logic          rst_core;
  logic          flush, flush_req, rd_retire, wr_retire, write_credit;
  logic [CW-1:0] pending_reads, pending_writes;
  logic          busy;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0]        exp_ar[$];
  logic [AW-1:0]        exp_aw[$];
  logic [DW+DW/8-1:0]   exp_w[$];

  hsv_core_mem_issue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  hsv_core_mem_issue #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PENDING_DEPTH(PD)
  ) dut (
    .clk_core       (clk_core),
    .rst_core       (rst_core),
    .flush          (flush),
    .flush_req      (flush_req),
    .rd_retire      (rd_retire),
    .wr_retire      (wr_retire),
    .write_credit   (write_credit),
    .pending_reads  (pending_reads),
    .pending_writes (pending_writes),
    .busy           (busy),
    .bus            (bus)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_core);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                           input logic mem, input logic ch, input logic mis, input logic fen);
    bus.req_valid       = 1'b1;
    bus.req_addr        = a;
    bus.req_write       = wr;
    bus.req_wdata       = d;
    bus.req_wstrb       = 4'hF;
    bus.req_is_memory   = mem;
    bus.req_commit_head = ch;
    bus.req_misaligned  = mis;
    bus.req_fence       = fen;
  endtask

  task automatic idle_req();
    bus.req_valid       = 1'b0;
    bus.req_addr        = '0;
    bus.req_write       = 1'b0;
    bus.req_wdata       = '0;
    bus.req_wstrb       = '0;
    bus.req_is_memory   = 1'b0;
    bus.req_commit_head = 1'b0;
    bus.req_misaligned  = 1'b0;
    bus.req_fence       = 1'b0;
  endtask

  task automatic ar_check(input string tag);
    chk({tag, "_arv"}, 64'(bus.ar_valid), 64'd1);
    tests++;
    assert (exp_ar.size() != 0) else begin
      fails++;
      $error("FAIL %s_arq: observed empty queue expected entry", tag);
    end
    if (exp_ar.size() != 0) chk({tag, "_ara"}, 64'(bus.ar_addr), 64'(exp_ar.pop_front()));
  endtask

  task automatic aw_check(input string tag);
    chk({tag, "_awv"}, 64'(bus.aw_valid), 64'd1);
    chk({tag, "_wv"}, 64'(bus.w_valid), 64'd1);
    tests++;
    assert ((exp_aw.size() != 0) && (exp_w.size() != 0)) else begin
      fails++;
      $error("FAIL %s_awq: observed empty queue expected entry", tag);
    end
    if ((exp_aw.size() != 0) && (exp_w.size() != 0)) begin
      chk({tag, "_awa"}, 64'(bus.aw_addr), 64'(exp_aw.pop_front()));
      chk({tag, "_wd"}, 64'({bus.w_data, bus.w_strb}), 64'(exp_w.pop_front()));
    end
  endtask

  task automatic ready_is(input string tag, input logic exp);
    #1;
    chk(tag, 64'(bus.req_ready), 64'(exp));
  endtask

  initial begin
    rst_core = 1'b1;
    flush = 1'b0; flush_req = 1'b0; rd_retire = 1'b0; wr_retire = 1'b0; write_credit = 1'b0;
    bus.ar_ready = 1'b1; bus.aw_ready = 1'b1; bus.w_ready = 1'b1;
    idle_req();
    repeat (3) cyc();

    // Reset state
    chk("rst_arv", 64'(bus.ar_valid), 64'd0);
    chk("rst_awv", 64'(bus.aw_valid), 64'd0);
    chk("rst_wv", 64'(bus.w_valid), 64'd0);
    chk("rst_pr", 64'(pending_reads), 64'd0);
    chk("rst_pw", 64'(pending_writes), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    ready_is("rst_ready", 1'b0);
    rst_core = 1'b0;
    cyc();

    // Word-aligned read issue and retire
    drive_req(32'h1003, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t1_ready", 1'b1);
    exp_ar.push_back(32'h1000);
    cyc(); idle_req();
    ar_check("t1");
    chk("t1_pr1", 64'(pending_reads), 64'd1);
    chk("t1_busy1", 64'(busy), 64'd1);
    rd_retire = 1'b1;
    cyc(); rd_retire = 1'b0;
    chk("t1_pr0", 64'(pending_reads), 64'd0);
    chk("t1_arv0", 64'(bus.ar_valid), 64'd0);
    chk("t1_busy0", 64'(busy), 64'd0);

    // Misaligned: accepted, no traffic
    drive_req(32'h1102, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    ready_is("mis_ready", 1'b1);
    cyc(); idle_req();
    chk("mis_arv", 64'(bus.ar_valid), 64'd0);
    chk("mis_pr", 64'(pending_reads), 64'd0);

    // Read-after-write ordering on the same word
    drive_req(32'h2000, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    ready_is("t2_wr_ready", 1'b1);
    exp_aw.push_back(32'h2000); exp_w.push_back({32'hDEADBEEF, 4'hF});
    cyc(); idle_req();
    aw_check("t2");
    chk("t2_pw1", 64'(pending_writes), 64'd1);
    drive_req(32'h2004, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t2_other_ready", 1'b1);
    exp_ar.push_back(32'h2004);
    cyc(); idle_req();
    ar_check("t2_other");
    drive_req(32'h2000, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t2_stall0", 1'b0);
    cyc();
    ready_is("t2_stall1", 1'b0);
    wr_retire = 1'b1;
    ready_is("t2_stall2", 1'b0);
    cyc(); wr_retire = 1'b0;
    ready_is("t2_go", 1'b1);
    exp_ar.push_back(32'h2000);
    cyc(); idle_req();
    ar_check("t2_same");
    chk("t2_pr2", 64'(pending_reads), 64'd2);
    chk("t2_pw0", 64'(pending_writes), 64'd0);
    rd_retire = 1'b1;
    cyc(); cyc(); rd_retire = 1'b0;
    chk("t2_pr0", 64'(pending_reads), 64'd0);

    // Credit-gated memory write, commit-head I/O write
    drive_req(32'h3000, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t3_nocred0", 1'b0);
    cyc();
    ready_is("t3_nocred1", 1'b0);
    write_credit = 1'b1;
    ready_is("t3_nocred2", 1'b0);
    cyc(); write_credit = 1'b0;
    ready_is("t3_cred", 1'b1);
    exp_aw.push_back(32'h3000); exp_w.push_back({32'h12345678, 4'hF});
    cyc(); idle_req();
    aw_check("t3_mem");
    drive_req(32'h3010, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t3_cred_back0", 1'b0);
    bus.req_is_memory = 1'b0; bus.req_commit_head = 1'b1;
    ready_is("t3_io_ready", 1'b1);
    exp_aw.push_back(32'h3010); exp_w.push_back({32'hCAFEF00D, 4'hF});
    cyc(); idle_req();
    aw_check("t3_io");
    chk("t3_pw2", 64'(pending_writes), 64'd2);
    wr_retire = 1'b1;
    cyc(); cyc(); wr_retire = 1'b0;
    chk("t3_pw0", 64'(pending_writes), 64'd0);

    // AW held under backpressure across a flush
    bus.aw_ready = 1'b0;
    drive_req(32'h4000, 1'b1, 32'h44444444, 1'b0, 1'b1, 1'b0, 1'b0);
    ready_is("t4_ready", 1'b1);
    exp_aw.push_back(32'h4000); exp_w.push_back({32'h44444444, 4'hF});
    cyc(); idle_req();
    aw_check("t4");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        flush = 1'b1;
        drive_req(32'h5000, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        ready_is("t4_flush_drop", 1'b0);
      end
      chk($sformatf("t4_awv%0d", i), 64'(bus.aw_valid), 64'd1);
      chk($sformatf("t4_awa%0d", i), 64'(bus.aw_addr), 64'h4000);
      chk($sformatf("t4_pw%0d", i), 64'(pending_writes), 64'd1);
      cyc(); flush = 1'b0; idle_req();
    end
    chk("t4_no_ar", 64'(bus.ar_valid), 64'd0);
    chk("t4_pr0", 64'(pending_reads), 64'd0);
    bus.aw_ready = 1'b1;
    cyc();
    chk("t4_awv_done", 64'(bus.aw_valid), 64'd0);
    wr_retire = 1'b1;
    cyc(); wr_retire = 1'b0;
    chk("t4_pw0", 64'(pending_writes), 64'd0);

    // Fill the read FIFO, then push-through-pop at full
    for (int i = 0; i < PD; i++) begin
      drive_req(32'h6000 + 32'(i * 4), 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      ready_is($sformatf("t5_fill%0d", i), 1'b1);
      exp_ar.push_back(32'h6000 + 32'(i * 4));
      cyc(); idle_req();
      ar_check($sformatf("t5_fill%0d", i));
    end
    chk("t5_full", 64'(pending_reads), 64'(PD));
    drive_req(32'h7000, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t5_stall0", 1'b0);
    cyc();
    ready_is("t5_stall1", 1'b0);
    rd_retire = 1'b1;
    ready_is("t5_swap", 1'b1);
    exp_ar.push_back(32'h7000);
    cyc(); rd_retire = 1'b0; idle_req();
    ar_check("t5_swap");
    chk("t5_still_full", 64'(pending_reads), 64'(PD));
    rd_retire = 1'b1;
    repeat (PD) cyc();
    chk("t5_empty", 64'(pending_reads), 64'd0);
    cyc(); rd_retire = 1'b0;
    chk("t5_underflow", 64'(pending_reads), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);

    // Fence waits for retires and an idle AR channel
    drive_req(32'h8000, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t6_rd0", 1'b1);
    exp_ar.push_back(32'h8000);
    cyc(); idle_req();
    ar_check("t6_rd0");
    drive_req(32'h8004, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t6_rd1", 1'b1);
    exp_ar.push_back(32'h8004);
    cyc(); idle_req();
    ar_check("t6_rd1");
    bus.ar_ready = 1'b0;
    chk("t6_pr2", 64'(pending_reads), 64'd2);
    drive_req(32'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    ready_is("t6_f0", 1'b0);
    cyc();
    ready_is("t6_f1", 1'b0);
    rd_retire = 1'b1;
    cyc(); cyc(); rd_retire = 1'b0;
    ready_is("t6_f2", 1'b0);
    chk("t6_pr0", 64'(pending_reads), 64'd0);
    chk("t6_arv_held", 64'(bus.ar_valid), 64'd1);
    chk("t6_ara_held", 64'(bus.ar_addr), 64'h8004);
    bus.ar_ready = 1'b1;
    cyc();
    ready_is("t6_pulse", 1'b1);
    chk("t6_arv0", 64'(bus.ar_valid), 64'd0);
    cyc(); idle_req();
    ready_is("t6_after", 1'b0);

    // Fence interrupted by flush_req: DRAIN blocks reads, writes need credit
    drive_req(32'h9000, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t7_rd", 1'b1);
    exp_ar.push_back(32'h9000);
    cyc(); idle_req();
    ar_check("t7_rd");
    drive_req(32'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    ready_is("t7_f0", 1'b0);
    cyc();
    ready_is("t7_f1", 1'b0);
    flush_req = 1'b1;
    ready_is("t7_fr", 1'b0);
    cyc(); flush_req = 1'b0; idle_req();
    drive_req(32'h9100, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t7_drain_rd0", 1'b0);
    cyc();
    ready_is("t7_drain_rd1", 1'b0);
    chk("t7_no_ar0", 64'(bus.ar_valid), 64'd0);
    cyc();
    chk("t7_no_ar1", 64'(bus.ar_valid), 64'd0);
    drive_req(32'h9200, 1'b1, 32'h99998888, 1'b0, 1'b1, 1'b0, 1'b0);
    ready_is("t7_drain_io_nocred", 1'b0);
    bus.req_is_memory = 1'b1; bus.req_commit_head = 1'b0;
    write_credit = 1'b1;
    cyc(); write_credit = 1'b0;
    ready_is("t7_drain_wr", 1'b1);
    exp_aw.push_back(32'h9200); exp_w.push_back({32'h99998888, 4'hF});
    cyc(); idle_req();
    aw_check("t7_drain_wr");
    flush = 1'b1;
    cyc(); flush = 1'b0;
    chk("t7_flush_pr", 64'(pending_reads), 64'd1);
    chk("t7_flush_pw", 64'(pending_writes), 64'd1);
    drive_req(32'h9100, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    ready_is("t7_run_rd", 1'b1);
    exp_ar.push_back(32'h9100);
    cyc(); idle_req();
    ar_check("t7_run_rd");
    rd_retire = 1'b1;
    cyc(); cyc(); rd_retire = 1'b0;
    wr_retire = 1'b1;
    cyc(); wr_retire = 1'b0;
    chk("t7_pr0", 64'(pending_reads), 64'd0);
    chk("t7_pw0", 64'(pending_writes), 64'd0);

    // Reset while a write is stuck on the bus
    bus.aw_ready = 1'b0;
    drive_req(32'hA000, 1'b1, 32'h0A0A0A0A, 1'b0, 1'b1, 1'b0, 1'b0);
    ready_is("t8_ready", 1'b1);
    cyc(); idle_req();
    chk("t8_awv1", 64'(bus.aw_valid), 64'd1);
    chk("t8_pw1", 64'(pending_writes), 64'd1);
    rst_core = 1'b1;
    cyc(); rst_core = 1'b0;
    chk("t8_awv0", 64'(bus.aw_valid), 64'd0);
    chk("t8_wv0", 64'(bus.w_valid), 64'd0);
    chk("t8_pw0", 64'(pending_writes), 64'd0);
    chk("t8_busy0", 64'(busy), 64'd0);
    bus.aw_ready = 1'b1;

    chk("sb_ar_empty", 64'(exp_ar.size()), 64'd0);
    chk("sb_aw_empty", 64'(exp_aw.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
